instruction_fetch_unit: RTL and testbench

Front-end stage of the 8-bit single-cycle CPU. It holds the program counter and fetches 32-bit instructions from instruction memory through a busy-wait handshake. It latches each instruction and presents the decoded fields (OPCODE to the control unit; register addresses and immediate to the register file and ALU muxes). It then advances the PC sequentially, or to a branch/jump target, once the datapath commits the instruction.

---
 rtl/instruction_fetch_unit_if.sv | 12 +
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory fetch bus: the fetch unit drives read/address, memory answers with data/busywait.
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                read;
    logic [PC_WIDTH-1:0] address;
    logic [31:0]         readdata;
    logic                busywait;

    modport master (output read, output address, input readdata, input busywait);
    modport slave  (input read, input address, output readdata, output busywait);
endinterface

// File: rtl/instruction_fetch_unit.sv
// CPU front end: holds the PC, fetches over a busy-wait bus, latches the instruction and
// redirects the PC on the commit cycle.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_fetch_unit_if.master imem,
    input  logic                    hold,
    input  logic                    jump,
    input  logic                    branch_taken,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [31:0]             instruction,
    output logic [7:0]              opcode,
    output logic [7:0]              offset,
    output logic [2:0]              dest,
    output logic [2:0]              src1,
    output logic [2:0]              src2,
    output logic [7:0]              immediate,
    output logic                    instr_valid,
    output logic                    commit
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t              state;
    logic                read_q;
    logic                valid_q;
    logic [PC_WIDTH-1:0] step;
    logic [PC_WIDTH-1:0] next_pc;

    assign opcode    = instruction[31:24];
    assign offset    = instruction[23:16];
    assign dest      = instruction[18:16];
    assign src1      = instruction[10:8];
    assign src2      = instruction[2:0];
    assign immediate = instruction[7:0];

    assign imem.read    = read_q;
    assign imem.address = pc;
    assign instr_valid  = valid_q;
    assign commit       = valid_q & ~hold;

    // Offset is a signed word count; the PC increment is folded into the same adder.
    always_comb begin
        step = PC_WIDTH'(4);
        if (jump | branch_taken)
            step = PC_WIDTH'(4) + {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
    end
    assign next_pc = pc + step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            read_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= FETCH;
                    read_q <= 1'b1;
                end
                FETCH: begin
                    if (!imem.busywait) begin
                        instruction <= imem.readdata;
                        state       <= ISSUE;
                        read_q      <= 1'b0;
                        valid_q     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        pc      <= next_pc;
                        state   <= FETCH;
                        read_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    read_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Cycle-by-cycle vector bench for the fetch unit, plus a wrap-around sequence on a second instance.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance 1: RESET_PC = 0
    logic        rst1, hold1, jmp1, br1;
    logic [31:0] pc1, instr1;
    logic [7:0]  opc1, off1, imm1;
    logic [2:0]  dst1, s1_1, s2_1;
    logic        vld1, cmt1;
    instruction_fetch_unit_if #(.PC_WIDTH(32)) bus1 ();

    instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut1 (
        .clk(clk), .reset(rst1), .imem(bus1), .hold(hold1), .jump(jmp1),
        .branch_taken(br1), .pc(pc1), .instruction(instr1), .opcode(opc1),
        .offset(off1), .dest(dst1), .src1(s1_1), .src2(s2_1), .immediate(imm1),
        .instr_valid(vld1), .commit(cmt1)
    );

    // Instance 2: RESET_PC at the top of the address space
    logic        rst2, hold2, jmp2, br2;
    logic [31:0] pc2, instr2;
    logic [7:0]  opc2, off2, imm2;
    logic [2:0]  dst2, s1_2, s2_2;
    logic        vld2, cmt2;
    instruction_fetch_unit_if #(.PC_WIDTH(32)) bus2 ();

    instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(rst2), .imem(bus2), .hold(hold2), .jump(jmp2),
        .branch_taken(br2), .pc(pc2), .instruction(instr2), .opcode(opc2),
        .offset(off2), .dest(dst2), .src1(s1_2), .src2(s2_2), .immediate(imm2),
        .instr_valid(vld2), .commit(cmt2)
    );

    typedef struct {
        logic        rst, bw;
        logic [31:0] rd;
        logic        hold, jmp, br;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid, e_commit;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic bw, input logic [31:0] rd,
                       input logic hold, input logic jmp, input logic br,
                       input logic e_read, input logic [31:0] e_addr,
                       input logic e_valid, input logic e_commit, input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.bw = bw; v.rd = rd; v.hold = hold; v.jmp = jmp; v.br = br;
        v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_commit = e_commit; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    initial begin
        //    rst bw rd            hd jp br | read addr   vld cmt instr
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h00, 0, 0, 32'h0);          // cycle 0: IDLE
        add(0, 0, 32'h02010003, 0, 0, 0,   1, 32'h00, 0, 0, 32'h0);          // first fetch
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h00, 1, 1, 32'h02010003);   // issue + commit
        add(0, 1, 32'h0,        0, 0, 0,   1, 32'h04, 0, 0, 32'h02010003);   // wait states
        add(0, 1, 32'hDEADBEEF, 0, 0, 0,   1, 32'h04, 0, 0, 32'h02010003);
        add(0, 1, 32'h0,        0, 0, 0,   1, 32'h04, 0, 0, 32'h02010003);
        add(0, 0, 32'h11000000, 0, 0, 0,   1, 32'h04, 0, 0, 32'h02010003);
        add(0, 0, 32'h0,        1, 0, 0,   0, 32'h04, 1, 0, 32'h11000000);   // hold x2
        add(0, 0, 32'h0,        1, 1, 0,   0, 32'h04, 1, 0, 32'h11000000);
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h04, 1, 1, 32'h11000000);
        add(0, 0, 32'h20030000, 0, 0, 1,   1, 32'h08, 0, 0, 32'h11000000);   // branch during fetch
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h08, 1, 1, 32'h20030000);
        add(0, 0, 32'h30000000, 0, 0, 0,   1, 32'h0C, 0, 0, 32'h20030000);
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h0C, 1, 1, 32'h30000000);
        add(0, 0, 32'h40FE0000, 0, 0, 0,   1, 32'h10, 0, 0, 32'h30000000);
        add(0, 0, 32'h0,        0, 0, 1,   0, 32'h10, 1, 1, 32'h40FE0000);   // branch -2 words
        add(0, 0, 32'h60000000, 0, 0, 0,   1, 32'h0C, 0, 0, 32'h40FE0000);
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h0C, 1, 1, 32'h60000000);
        add(0, 0, 32'h50030000, 0, 0, 0,   1, 32'h10, 0, 0, 32'h60000000);
        add(0, 0, 32'h0,        0, 1, 0,   0, 32'h10, 1, 1, 32'h50030000);   // jump +3 words
        add(0, 0, 32'h70010000, 0, 0, 0,   1, 32'h20, 0, 0, 32'h50030000);
        add(0, 0, 32'h0,        0, 1, 1,   0, 32'h20, 1, 1, 32'h70010000);   // both: same target
        add(0, 1, 32'h0,        0, 0, 0,   1, 32'h28, 0, 0, 32'h70010000);
        add(1, 1, 32'h12345678, 0, 0, 0,   1, 32'h28, 0, 0, 32'h70010000);   // reset mid-fetch
        add(0, 0, 32'hAAAAAAAA, 0, 0, 0,   0, 32'h00, 0, 0, 32'h0);          // late data ignored
        add(0, 0, 32'h80050000, 0, 0, 0,   1, 32'h00, 0, 0, 32'h0);
        add(1, 0, 32'h0,        0, 1, 0,   0, 32'h00, 1, 1, 32'h80050000);   // reset mid-issue
        add(0, 0, 32'h0,        0, 0, 0,   0, 32'h00, 0, 0, 32'h0);
        add(0, 0, 32'h02010003, 0, 0, 0,   1, 32'h00, 0, 0, 32'h0);

        rst1 = 1'b1; hold1 = 1'b0; jmp1 = 1'b0; br1 = 1'b0;
        bus1.busywait = 1'b0; bus1.readdata = '0;
        rst2 = 1'b1; hold2 = 1'b0; jmp2 = 1'b0; br2 = 1'b0;
        bus2.busywait = 1'b0; bus2.readdata = '0;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst1 = vecs[i].rst; bus1.busywait = vecs[i].bw; bus1.readdata = vecs[i].rd;
            hold1 = vecs[i].hold; jmp1 = vecs[i].jmp; br1 = vecs[i].br;
            #1;
            chk($sformatf("read[%0d]", i),   32'(bus1.read),  32'(vecs[i].e_read));
            chk($sformatf("addr[%0d]", i),   bus1.address,    vecs[i].e_addr);
            chk($sformatf("pc[%0d]", i),     pc1,             vecs[i].e_addr);
            chk($sformatf("valid[%0d]", i),  32'(vld1),       32'(vecs[i].e_valid));
            chk($sformatf("commit[%0d]", i), 32'(cmt1),       32'(vecs[i].e_commit));
            chk($sformatf("instr[%0d]", i),  instr1,          vecs[i].e_instr);
            chk($sformatf("fields[%0d]", i),
                {opc1, off1, 2'b00, dst1, s1_1, s2_1, imm1},
                {vecs[i].e_instr[31:24], vecs[i].e_instr[23:16], 2'b00,
                 vecs[i].e_instr[18:16], vecs[i].e_instr[10:8],
                 vecs[i].e_instr[2:0], vecs[i].e_instr[7:0]});
        end

        // Wrap-around on the second instance
        @(negedge clk); rst2 = 1'b0; #1;
        chk("wrap_reset_addr", bus2.address, 32'hFFFF_FFFC);
        chk("wrap_reset_read", 32'(bus2.read), 32'd0);
        @(negedge clk); bus2.readdata = 32'h0000_0000; #1;
        chk("wrap_fetch_read", 32'(bus2.read), 32'd1);
        @(negedge clk); #1;
        chk("wrap_loadi_commit", 32'(cmt2), 32'd1);
        chk("wrap_loadi_opcode", 32'(opc2), 32'h0);
        @(negedge clk); bus2.readdata = 32'h0080_0000; #1;
        chk("wrap_seq_addr", bus2.address, 32'h0000_0000);
        chk("wrap_seq_read", 32'(bus2.read), 32'd1);
        @(negedge clk); jmp2 = 1'b1; #1;
        chk("wrap_neg_offset", 32'(off2), 32'h80);
        chk("wrap_neg_commit", 32'(cmt2), 32'd1);
        @(negedge clk); jmp2 = 1'b0; #1;
        chk("wrap_neg_addr", bus2.address, 32'hFFFF_FE04);
        chk("wrap_neg_pc", pc2, 32'hFFFF_FE04);
        chk("wrap_neg_read", 32'(bus2.read), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
